// File: rtl/dma_mem_ctrl.sv
// Sequencer in front of the DMA write/read engines: latches a command, runs the
// req/ack handshake, snoops stream beats for completion and reports status.
module dma_mem_ctrl #(
    parameter int unsigned       MEM_AW  = 16,
    parameter int unsigned       LEN_MIN = 4,
    parameter int unsigned       TOUT_W  = 16,
    parameter logic [TOUT_W-1:0] TOUT    = {TOUT_W{1'b1}}
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_start_i,
    input  logic              cmd_dir_i,
    input  logic              cmd_abort_i,
    input  logic [MEM_AW-1:0] cmd_addr_i,
    input  logic [MEM_AW-1:0] cmd_len_i,
    output logic              wr_req_o,
    input  logic              wr_ack_i,
    output logic [MEM_AW-1:0] wr_addr_o,
    input  logic              wr_beat_i,
    input  logic              wr_last_i,
    output logic              rd_req_o,
    input  logic              rd_ack_i,
    output logic [MEM_AW-1:0] rd_addr_o,
    output logic [MEM_AW-1:0] rd_len_o,
    input  logic              rd_beat_i,
    input  logic              rd_last_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [2:0]        status_o,
    output logic [MEM_AW-1:0] beat_cnt_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_WAIT_ACK = 3'd2;
    localparam logic [2:0] S_XFER     = 3'd3;
    localparam logic [2:0] S_RELEASE  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_LEN      = 3'd1;
    localparam logic [2:0] ST_TIMEOUT      = 3'd2;
    localparam logic [2:0] ST_ABORT        = 3'd3;
    localparam logic [2:0] ST_LEN_MISMATCH = 3'd4;

    localparam logic [MEM_AW-1:0] LP_LEN_MIN = MEM_AW'(LEN_MIN);
    localparam logic [MEM_AW-1:0] LP_CNT_ONE = MEM_AW'(1);
    localparam logic [TOUT_W-1:0] LP_TOUT_ONE = TOUT_W'(1);

    logic [2:0]        r_state;
    logic              r_dir;
    logic [MEM_AW-1:0] r_addr;
    logic [MEM_AW-1:0] r_len;
    logic [MEM_AW-1:0] r_beat_cnt;
    logic [TOUT_W-1:0] r_tout;
    logic              r_wr_req;
    logic              r_rd_req;
    logic [2:0]        r_status;

    logic              w_ack;
    logic              w_beat;
    logic              w_last;
    logic              w_len_bad;
    logic              w_tout_hit;
    logic [MEM_AW-1:0] w_cnt_inc;
    logic [TOUT_W-1:0] w_tout_inc;

    // Only the engine selected by the latched direction is observed.
    assign w_ack  = r_dir ? rd_ack_i : wr_ack_i;
    assign w_last = r_dir ? rd_last_i : wr_last_i;
    assign w_beat = r_dir ? (rd_beat_i | rd_last_i) : (wr_beat_i | wr_last_i);

    assign w_len_bad  = (r_len == '0) || (r_len < LP_LEN_MIN);
    assign w_cnt_inc  = (r_beat_cnt == '1) ? r_beat_cnt : r_beat_cnt + LP_CNT_ONE;
    assign w_tout_inc = r_tout + LP_TOUT_ONE;
    // Fires on the edge where the idle count would reach TOUT.
    assign w_tout_hit = (TOUT != '0) && (w_tout_inc == TOUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_dir      <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
            r_tout     <= '0;
            r_wr_req   <= 1'b0;
            r_rd_req   <= 1'b0;
            r_status   <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_start_i) begin
                        r_dir      <= cmd_dir_i;
                        r_addr     <= cmd_addr_i;
                        r_len      <= cmd_len_i;
                        r_beat_cnt <= '0;
                        r_status   <= ST_OK;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_len_bad) begin
                        r_status <= ST_BAD_LEN;
                        r_state  <= S_DONE;
                    end else begin
                        r_wr_req <= ~r_dir;
                        r_rd_req <= r_dir;
                        r_tout   <= '0;
                        r_state  <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (cmd_abort_i) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_status <= ST_ABORT;
                        r_state  <= S_RELEASE;
                    end else if (w_tout_hit) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_RELEASE;
                    end else begin
                        r_tout <= w_tout_inc;
                        if (w_ack) begin
                            r_state <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    if (w_beat) begin
                        r_beat_cnt <= w_cnt_inc;
                        r_tout     <= '0;
                    end else begin
                        r_tout <= w_tout_inc;
                    end
                    // The read engine re-arms on the last-beat edge, so req must fall here.
                    if (w_last) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_status <= (w_cnt_inc == r_len) ? ST_OK : ST_LEN_MISMATCH;
                        r_state  <= S_RELEASE;
                    end else if (cmd_abort_i) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_status <= ST_ABORT;
                        r_state  <= S_RELEASE;
                    end else if (!w_beat && w_tout_hit) begin
                        r_wr_req <= 1'b0;
                        r_rd_req <= 1'b0;
                        r_status <= ST_TIMEOUT;
                        r_state  <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!w_ack) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wr_req_o   = r_wr_req;
    assign rd_req_o   = r_rd_req;
    assign wr_addr_o  = r_addr;
    assign rd_addr_o  = r_addr;
    assign rd_len_o   = r_len;
    assign busy_o     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o     = (r_state == S_DONE);
    assign status_o   = r_status;
    assign beat_cnt_o = r_beat_cnt;

endmodule

// File: doc/dma_mem_ctrl.md
# dma_mem_ctrl

Sequencing controller sitting directly upstream of the DMA write and read engines (`dma_mem_wr` / `dma_mem_rd`). It accepts a one-shot transfer command from the peripheral register bank and runs the four-phase `dma_req`/`dma_ack` handshake to the selected engine. It snoops the engine's AXI-Stream beats to detect completion and releases the request on the last beat. It reports busy/done/status, a beat count, and an inactivity timeout and abort path so software never hangs on a stalled stream.

## Interface
Parameters:
- `MEM_AW`, 16: memory address / length width.
- `LEN_MIN`, 4: minimum legal transfer length in words; must be ≥ read-engine `MEM_LATENCY`+1.
- `TOUT_W`, 16: timeout counter width.
- `TOUT`, 16'hFFFF: inactivity timeout in cycles; 0 disables the timeout.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `cmd_start_i`, in, 1: single-cycle start pulse.
- `cmd_dir_i`, in, 1: 0 = write to memory, 1 = read from memory.
- `cmd_abort_i`, in, 1: single-cycle abort pulse.
- `cmd_addr_i`, in, MEM_AW: start address.
- `cmd_len_i`, in, MEM_AW: transfer length in words.
- `wr_req_o`, out, 1: request to write engine.
- `wr_ack_i`, in, 1: write engine ack.
- `wr_addr_o`, out, MEM_AW: write start address.
- `wr_beat_i`, in, 1: snoop of `s_axis` tvalid (tready is constant 1).
- `wr_last_i`, in, 1: snoop of `s_axis` tvalid & tlast.
- `rd_req_o`, out, 1: request to read engine.
- `rd_ack_i`, in, 1: read engine ack.
- `rd_addr_o`, out, MEM_AW: read start address.
- `rd_len_o`, out, MEM_AW: read length.
- `rd_beat_i`, in, 1: snoop of `m_axis` tvalid & tready.
- `rd_last_i`, in, 1: snoop of `m_axis` tvalid & tready & tlast.
- `busy_o`, out, 1: high from start acceptance until done.
- `done_o`, out, 1: one-cycle completion pulse.
- `status_o`, out, 3: 0 OK, 1 BAD_LEN, 2 TIMEOUT, 3 ABORT, 4 LEN_MISMATCH. Held until the next accepted start.
- `beat_cnt_o`, out, MEM_AW: beats counted in the current or last transfer; saturates at all-ones.

## Operation
- The command (dir, addr, len) is latched on an accepted start. Address and length outputs are driven from the latched copy and stay stable while busy.
- `cmd_start_i` is accepted only in IDLE; it is ignored otherwise. `cmd_abort_i` is ignored in IDLE.
- States and transitions:
  - IDLE: on start, go to CHECK.
  - CHECK:
    - `len==0` or `len<LEN_MIN`: status = BAD_LEN, go to DONE; no request is ever raised.
    - Otherwise: assert the selected `*_req_o`, go to WAIT_ACK.
  - WAIT_ACK: on selected ack = 1, go to XFER.
  - XFER: count selected beats.
    - On selected last: drop req in that same cycle (registered low on that edge), go to RELEASE.
    - Status is OK if `beat_cnt == len` (including the last beat), else LEN_MISMATCH.
  - RELEASE: req low; on selected ack = 0, go to DONE.
  - DONE: `done_o` = 1 for one cycle, `busy_o` = 0, go to IDLE.
- Timeout:
  - The counter clears on entering WAIT_ACK and on every selected beat, and increments otherwise in WAIT_ACK and XFER.
  - When it reaches TOUT (TOUT ≠ 0): drop req, status = TIMEOUT, go to RELEASE.
- Abort in WAIT_ACK or XFER: drop req, status = ABORT, go to RELEASE.
- Priority within one cycle: last > abort > timeout.
- Beats on the non-selected direction are ignored.
- Dropping req on the last-beat edge is mandatory. The read engine returns to idle on that edge and would restart if req were still high.

## Timing
- Reset: all outputs 0, state IDLE, status 0, beat count 0. An asynchronous assert mid-transfer drops req immediately; the engines recover through their own reset.
- Start to req high: 2 cycles (start → CHECK → req registered).
- Start to `busy_o`: 1 cycle. BAD_LEN start to `done_o`: 2 cycles.
- Last beat to req low: the next edge.
- Ack low to `done_o`: 1 cycle.
- `beat_cnt_o` clears on start acceptance and updates one cycle after each beat.

## Test plan
- Write, addr = 0x10, len = 8: 8 beats on `wr_beat_i`, last on beat 8 → `wr_req_o` low the cycle after the last beat; `done_o` pulses after `wr_ack_i` falls; status 0; `beat_cnt_o` = 8; `rd_req_o` never asserts.
- Read, addr = 0x20, len = 16, `m_axis` tready toggling 50%: 16 ready beats → `rd_req_o` drops on the last-beat edge; no second request; status 0; count 16.
- Start with len = 0 and again with len = 3 (LEN_MIN = 4) → no req; `done_o` 2 cycles after start; status 1.
- TOUT = 32, write, stall after 2 beats → req drops 32 cycles after beat 2; status 2; count 2; done after ack falls.
- Abort during XFER on a read, a second start while busy, and abort coincident with the last beat → abort gives status 3; the second start is ignored; abort coincident with last gives status 0.
- Reset asserted mid-read → `rd_req_o`, `busy_o` and `status_o` are 0 immediately; after release a fresh len = 8 read completes with status 0.
